// File: rtl/etch_pkg.sv
// Shared definitions for the trace tile display path.
// Holds the tile grid geometry, the three display colours, the per-pixel
// pipeline record used by the renderer, and the tile-RAM address function
// that both tile RAM ports use.
package etch_pkg;

  localparam int MAX_X   = 80;  // tile columns (640/8)
  localparam int MAX_Y   = 30;  // tile rows (480/16)
  localparam int TILE_W  = 8;
  localparam int TILE_H  = 16;
  localparam int ADDR_W  = 12;
  localparam int TILE_DW = 7;

  localparam logic [11:0] BG_RGB     = 12'hCCC;
  localparam logic [11:0] TRACE_RGB  = 12'h222;
  localparam logic [11:0] CURSOR_RGB = 12'hF00;

  // One pixel as it travels down the render pipeline.
  typedef struct packed {
    logic [6:0] col;  // tile column, x[9:3]
    logic [2:0] px;   // pixel column inside the tile
    logic [4:0] row;  // tile row, y[8:4]
    logic [3:0] py;   // pixel row inside the tile
    logic       vid;  // video_on
    logic       inr;  // tile lies inside the MAX_X x MAX_Y grid
  } pix_t;

  // Tile RAM address: row-major with a 128-entry row pitch.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [4:0] row,
                                                  input logic [6:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/trace_tile_renderer_if.sv
// Read port (port B) of the dual-port tile RAM.
//   ram_addr_r : tile address, driven by the renderer
//   ram_dout   : tile word, returned by the RAM one clk after the address
// master = renderer, slave = RAM.
interface trace_tile_renderer_if;
  import etch_pkg::*;

  logic [ADDR_W-1:0]  ram_addr_r;
  logic [TILE_DW-1:0] ram_dout;

  modport master (output ram_addr_r, input  ram_dout);
  modport slave  (input  ram_addr_r, output ram_dout);
endinterface

// File: rtl/trace_tile_renderer_blink_timer.sv
// Cursor blink timer.
// Counts frame starts; every BLINK_FRAMES frame starts it flips blink_on.
//   clk_100MHz  : system clock
//   reset_n     : synchronous active-low reset (blink_on returns to 1)
//   p_tick      : pixel enable
//   frame_start : scan position is (0,0); only honoured with p_tick
//   blink_on    : cursor visible
module blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk_100MHz,
  input  logic reset_n,
  input  logic p_tick,
  input  logic frame_start,
  output logic blink_on
);

  localparam logic [5:0] LAST = 6'(BLINK_FRAMES - 1);

  logic [5:0] cnt_q, cnt_d;
  logic       blink_q, blink_d;

  // NOTE: every signal assigned in an always_comb gets a default first so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (p_tick && frame_start) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; the reset is synchronous, so it sits inside
  // the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      blink_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink_on = blink_q;

endmodule

// File: rtl/trace_tile_renderer.sv
// Video-side reader of the trace tile RAM.
// Turns the scan position into a tile-RAM read address, classifies the
// returned tile word as traced/untraced, overlays a blinking cursor outline
// on the cursor tile latched at frame start, and registers 12-bit RGB.
// Latency from pixel presentation to rgb is two p_ticks.
//   clk_100MHz, reset_n : clock, synchronous active-low reset
//   p_tick              : pixel enable; the whole pipeline advances on it
//   video_on, x, y      : scan position from the sync generator
//   cur_x, cur_y        : cursor tile, sampled only at frame start
//   ram                 : tile RAM read port (address out, data in)
//   rgb                 : registered pixel colour
module trace_tile_renderer
  import etch_pkg::*;
#(
  parameter int          MAX_X        = etch_pkg::MAX_X,
  parameter int          MAX_Y        = etch_pkg::MAX_Y,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] BG_RGB       = etch_pkg::BG_RGB,
  parameter logic [11:0] TRACE_RGB    = etch_pkg::TRACE_RGB,
  parameter logic [11:0] CURSOR_RGB   = etch_pkg::CURSOR_RGB
) (
  input  logic                  clk_100MHz,
  input  logic                  reset_n,
  input  logic                  p_tick,
  input  logic                  video_on,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic [6:0]            cur_x,
  input  logic [4:0]            cur_y,
  trace_tile_renderer_if.master ram,
  output logic [11:0]           rgb
);

  localparam logic [6:0] MAX_COL = 7'(MAX_X);
  localparam logic [4:0] MAX_ROW = 5'(MAX_Y);
  localparam logic [2:0] LAST_PX = 3'(TILE_W - 1);
  localparam logic [3:0] LAST_PY = 4'(TILE_H - 1);

  pix_t               pix_in;
  pix_t               s1_q, s2_q;
  logic [TILE_DW-1:0] s2_tile_q;
  logic [6:0]         cx_q;
  logic [4:0]         cy_q;
  logic [11:0]        rgb_q, rgb_d;
  logic               frame_start;
  logic               cursor_hit;
  logic               blink_on;

  assign ram.ram_addr_r = tile_addr(y[8:4], x[9:3]);
  assign frame_start    = (x == 10'd0) && (y == 10'd0);

  always_comb begin
    pix_in.col = x[9:3];
    pix_in.px  = x[2:0];
    pix_in.row = y[8:4];
    pix_in.py  = y[3:0];
    pix_in.vid = video_on;
    pix_in.inr = (x[9:3] < MAX_COL) && (y[8:4] < MAX_ROW);
  end

  // An out-of-range latched cursor can never equal an in-range tile, and
  // out-of-range tiles are blanked first, so no extra range test is needed.
  assign cursor_hit = (s2_q.col == cx_q) && (s2_q.row == cy_q) &&
                      ((s2_q.px == 3'd0) || (s2_q.px == LAST_PX) ||
                       (s2_q.py == 4'd0) || (s2_q.py == LAST_PY));

  always_comb begin
    rgb_d = BG_RGB;
    if (!s2_q.vid || !s2_q.inr)      rgb_d = 12'h000;
    else if (cursor_hit && blink_on) rgb_d = CURSOR_RGB;
    else if (s2_tile_q != '0)        rgb_d = TRACE_RGB;
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s2_tile_q <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      rgb_q     <= '0;
    end else if (p_tick) begin
      s1_q      <= pix_in;
      s2_q      <= s1_q;
      s2_tile_q <= ram.ram_dout;  // data for the address presented with s1_q
      rgb_q     <= rgb_d;
      // Cursor moves only at frame start so it never tears mid-frame.
      if (frame_start) begin
        cx_q <= cur_x;
        cy_q <= cur_y;
      end
    end
  end

  blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk_100MHz  (clk_100MHz),
    .reset_n     (reset_n),
    .p_tick      (p_tick),
    .frame_start (frame_start),
    .blink_on    (blink_on)
  );

  assign rgb = rgb_q;

endmodule

// File: tb/tb_trace_tile_renderer.sv
// Self-checking bench for trace_tile_renderer: directed steps with random
// tile contents and random scan pixels, checked against a per-frame model.
module tb_trace_tile_renderer;
  import etch_pkg::*;

  localparam int BLINK = 30;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        p_tick = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic [6:0]  cur_x = '0;
  logic [4:0]  cur_y = '0;
  logic [11:0] rgb;

  trace_tile_renderer_if rif ();

  trace_tile_renderer #(.BLINK_FRAMES(BLINK)) dut (
    .clk_100MHz (clk),
    .reset_n    (reset_n),
    .p_tick     (p_tick),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .ram        (rif),
    .rgb        (rgb)
  );

  always #5 clk = ~clk;

  // Tile RAM port B: registered read, sampled on each pixel tick.
  logic [6:0] mem [4096];
  initial rif.ram_dout = '0;
  always @(posedge clk) if (p_tick) rif.ram_dout <= mem[rif.ram_addr_r];

  int checks = 0;
  int failures = 0;

  // Reference state: frame starts since reset and cursor latched at the
  // most recent one.
  int          frame_k = 0;
  int          lat_cx = 0, lat_cy = 0;
  logic [11:0] exp_q[$];
  logic [11:0] last_rgb = '0;

  task automatic check(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model(input int px, input int py,
                                        input bit vo);
    int tx = px / 8;
    int ty = (py / 16) % 32;
    int ox = px % 8;
    int oy = py % 16;
    bit on_edge = (ox == 0) || (ox == 7) || (oy == 0) || (oy == 15);
    bit blink = ((frame_k / BLINK) % 2) == 0;
    if (!vo || tx >= MAX_X || ty >= MAX_Y) return 12'h000;
    if (tx == lat_cx && ty == lat_cy && on_edge && blink) return CURSOR_RGB;
    if (mem[ty * 128 + tx] != 7'd0) return TRACE_RGB;
    return BG_RGB;
  endfunction

  // Present one pixel for one tick; rgb for the pixel two ticks earlier is
  // checked right after the tick and again one clk later (must hold).
  task automatic pixel(input int px, input int py, input bit vo);
    logic [11:0] exp_out;
    @(negedge clk);
    x = 10'(px); y = 10'(py); video_on = vo; p_tick = 1'b1;
    #1 check("ram_addr", rif.ram_addr_r, 12'(((py / 16) % 32) * 128 + px / 8));
    if (px == 0 && py == 0) begin
      frame_k++;
      lat_cx = int'(cur_x);
      lat_cy = int'(cur_y);
    end
    exp_q.push_back(model(px, py, vo));
    @(posedge clk); #1;
    exp_out = exp_q.pop_front();
    check("rgb", rgb, exp_out);
    if (px == 0 && py == 0)
      check("blink_on", 12'(dut.blink_on), 12'(((frame_k / BLINK) % 2) == 0));
    @(negedge clk); p_tick = 1'b0;
    @(posedge clk); #1 check("rgb_hold", rgb, exp_out);
    last_rgb = exp_out;
  endtask

  task automatic rand_pixel();
    int px = $urandom_range(0, 639);
    int py = $urandom_range(0, 479);
    if (px == 0 && py == 0) px = 1;
    pixel(px, py, $urandom_range(0, 7) != 0);
  endtask

  // Two blanking pixels then (0,0): nothing visible is in flight when the
  // cursor latch and blink timer update.
  task automatic frame_start_seq();
    pixel(700, 490, 1'b0);
    pixel(700, 490, 1'b0);
    pixel(0, 0, 1'b1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset_n = 1'b0; p_tick = 1'b1; video_on = 1'b1; x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1 check("reset_rgb", rgb, 12'h000);
    check("reset_blink", 12'(dut.blink_on), 12'h001);
    @(negedge clk);
    reset_n = 1'b1; p_tick = 1'b0; video_on = 1'b0;
    frame_k = 0; lat_cx = 0; lat_cy = 0;
    exp_q.delete();
    exp_q.push_back(12'h000);
    exp_q.push_back(12'h000);
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(posedge clk); #1 check("stall_hold", rgb, last_rgb);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++)
      mem[i] = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom_range(1, 127));

    // Reset, then blank pixels stay black.
    reset_dut();
    for (int i = 0; i < 3; i++) pixel(100 + i, 100, 1'b0);

    // Address and two-tick latency, traced then untraced tile.
    mem[{5'd2, 7'd2}] = 7'h01;
    pixel(17, 35, 1'b1);
    pixel(300, 300, 1'b0);
    pixel(300, 300, 1'b0);
    mem[{5'd2, 7'd2}] = 7'h00;
    pixel(17, 35, 1'b1);
    pixel(300, 300, 1'b0);
    pixel(300, 300, 1'b0);

    // Cursor outline at tile (5,3).
    cur_x = 7'd5; cur_y = 5'd3;
    frame_start_seq();
    pixel(40, 48, 1'b1);
    pixel(47, 63, 1'b1);
    pixel(43, 55, 1'b1);
    pixel(44, 48, 1'b1);
    pixel(40, 57, 1'b1);
    pixel(48, 48, 1'b1);
    pixel(39, 63, 1'b1);
    for (int i = 0; i < 12; i++) rand_pixel();

    // Mid-frame cursor change is held until the next frame start.
    cur_x = 7'd5; cur_y = 5'd13;
    frame_start_seq();
    pixel(100, 200, 1'b1);
    cur_x = 7'd6;
    pixel(101, 200, 1'b1);
    pixel(40, 208, 1'b1);
    pixel(48, 208, 1'b1);
    pixel(55, 223, 1'b1);
    frame_start_seq();
    pixel(40, 208, 1'b1);
    pixel(48, 208, 1'b1);
    pixel(55, 223, 1'b1);
    stall(10);

    // Blink across frame starts 30 and 60.
    cur_x = 7'd10; cur_y = 5'd20;
    while (frame_k < 62) begin
      frame_start_seq();
      pixel(80, 320, 1'b1);
      pixel(87, 335, 1'b1);
      pixel(83, 327, 1'b1);
      rand_pixel();
    end

    // Range and blanking.
    pixel(639, 479, 1'b1);
    pixel(639, 479, 1'b0);
    pixel(650, 100, 1'b1);
    pixel(100, 490, 1'b1);
    cur_x = 7'd90; cur_y = 5'd3;
    frame_start_seq();
    for (int i = 0; i < 8; i++) pixel($urandom_range(0, 639), 48, 1'b1);
    pixel(720, 48, 1'b1);

    // Reset in the middle of visible pixels.
    pixel(17, 35, 1'b1);
    reset_dut();
    mem[{5'd2, 7'd2}] = 7'h05;
    pixel(17, 35, 1'b1);
    pixel(17, 36, 1'b1);
    pixel(0, 17, 1'b1);
    for (int i = 0; i < 6; i++) rand_pixel();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
